// File: rtl/mtl_pkg.sv
// Shared types and helpers for the LCD frame arbiter: FSM states, default sizes, buffer base lookup.
// Pure declarations; no latency or backpressure of its own.
package mtl_pkg;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_READY = 1'b1
    } arb_state_t;

    localparam int unsigned MTL_FRAME_WORDS = 384000;
    localparam int unsigned MTL_ADDR_W      = 24;

    // Buffer 0 sits at word 0, buffer 1 directly after it.
    function automatic logic [31:0] buf_base(input logic sel, input int unsigned frame_words);
        return sel ? 32'(frame_words) : 32'd0;
    endfunction

endpackage

// File: rtl/mtl_wr_fifo.sv
// Small synchronous FIFO holding pixel words until the SDRAM port is free; head is visible the cycle after push.
// Push is ignored when full and pop when empty; the caller gates both with full/empty.
module mtl_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         iCLK,
    input  logic         iRST_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]  wp_q, wp_d;
    logic [AW:0]  rp_q, rp_d;
    logic [W-1:0] mem_q [DEPTH];

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign head  = mem_q[rp_q[AW-1:0]];

    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        if (push && !full) begin
            wp_d = wp_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rp_d = rp_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push && !full) begin
            mem_q[wp_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mtl_frame_arbiter.sv
// Shares one SDRAM port between the LCD read stream (strict priority, zero-cycle pass-through) and buffered pixel writes.
// Writes drain at least one cycle after acceptance; oWR_READY drops when the FIFO is full or the back buffer is complete.
module mtl_frame_arbiter
    import mtl_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = MTL_FRAME_WORDS,
    parameter int unsigned ADDR_W      = MTL_ADDR_W,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iNewFrame,
    input  logic              iRD_REQ,
    input  logic              iWR_VALID,
    input  logic [31:0]       iWR_DATA,
    output logic              oWR_READY,
    output logic              oMEM_RD,
    output logic              oMEM_WR,
    output logic [ADDR_W-1:0] oMEM_ADDR,
    output logic [31:0]       oMEM_WDATA,
    output logic              oFrameSwap,
    output logic              oBufValid
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [CNT_W-1:0] FW_CNT    = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] FW_CNT_M1 = CNT_W'(FRAME_WORDS - 1);

    if (64'(FRAME_WORDS) * 64'd2 > (64'd1 << ADDR_W)) begin : g_addr_chk
        $error("mtl_frame_arbiter: two frame buffers do not fit in ADDR_W");
    end

    arb_state_t       state_q, state_d;
    logic             front_q, front_d;
    logic             buf_valid_q, buf_valid_d;
    logic             swap_q, swap_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_head;
    logic [ADDR_W-1:0] front_base, back_base;

    assign front_base = ADDR_W'(buf_base(front_q, FRAME_WORDS));
    assign back_base  = ADDR_W'(buf_base(!front_q, FRAME_WORDS));

    assign oWR_READY = (state_q == S_FILL) && !fifo_full && (acc_cnt_q < FW_CNT);
    assign fifo_push = iWR_VALID && oWR_READY;
    // Display reads always win the port; writes only drain in idle cycles.
    assign fifo_pop  = !fifo_empty && !iRD_REQ;

    mtl_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_wr_fifo (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .push   (fifo_push),
        .wdata  (iWR_DATA),
        .pop    (fifo_pop),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

    always_comb begin
        oMEM_RD    = iRD_REQ;
        oMEM_WR    = fifo_pop;
        oMEM_ADDR  = '0;
        oMEM_WDATA = '0;
        if (iRD_REQ) begin
            oMEM_ADDR = front_base + ADDR_W'(rd_cnt_q);
        end else if (fifo_pop) begin
            oMEM_ADDR  = back_base + ADDR_W'(wr_cnt_q);
            oMEM_WDATA = fifo_head;
        end
    end

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        buf_valid_d = buf_valid_q;
        swap_d      = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        acc_cnt_d   = acc_cnt_q;

        if (iNewFrame) begin
            rd_cnt_d = '0;
        end else if (iRD_REQ) begin
            rd_cnt_d = (rd_cnt_q == FW_CNT_M1) ? '0 : rd_cnt_q + CNT_W'(1);
        end

        if (fifo_pop) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
        if (fifo_push) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            S_FILL: begin
                if (wr_cnt_q == FW_CNT) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                // Swap only at a frame boundary so the display never tears.
                if (iNewFrame) begin
                    state_d     = S_FILL;
                    front_d     = !front_q;
                    buf_valid_d = 1'b1;
                    swap_d      = 1'b1;
                    wr_cnt_d    = '0;
                    acc_cnt_d   = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= S_FILL;
            front_q     <= 1'b0;
            buf_valid_q <= 1'b0;
            swap_q      <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            acc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            buf_valid_q <= buf_valid_d;
            swap_q      <= swap_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign oFrameSwap = swap_q;
    assign oBufValid  = buf_valid_q;

endmodule

// File: tb/tb_mtl_frame_arbiter.sv
// Scoreboarded bench for mtl_frame_arbiter with 16-word frames and a 4-entry write FIFO.
module tb_mtl_frame_arbiter;
    import mtl_pkg::*;

    localparam int FW = 16;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        iNewFrame, iRD_REQ, iWR_VALID;
    logic [31:0] iWR_DATA;
    logic        oWR_READY, oMEM_RD, oMEM_WR, oFrameSwap, oBufValid;
    logic [23:0] oMEM_ADDR;
    logic [31:0] oMEM_WDATA;

    mtl_frame_arbiter #(
        .FRAME_WORDS (FW),
        .ADDR_W      (24),
        .FIFO_DEPTH  (4)
    ) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iNewFrame  (iNewFrame),
        .iRD_REQ    (iRD_REQ),
        .iWR_VALID  (iWR_VALID),
        .iWR_DATA   (iWR_DATA),
        .oWR_READY  (oWR_READY),
        .oMEM_RD    (oMEM_RD),
        .oMEM_WR    (oMEM_WR),
        .oMEM_ADDR  (oMEM_ADDR),
        .oMEM_WDATA (oMEM_WDATA),
        .oFrameSwap (oFrameSwap),
        .oBufValid  (oBufValid)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [23:0] a;
        logic [31:0] d;
    } wr_t;

    logic [23:0] rd_q [$];
    wr_t         wr_q [$];
    int total = 0;
    int bad   = 0;

    // Reference model of the arbiter state.
    bit m_fill, m_front, m_valid, m_swap;
    int m_rd, m_wr, m_acc, m_occ;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bb(input bit s);
        return s ? 24'(FW) : 24'd0;
    endfunction

    task automatic model_reset();
        m_fill = 1; m_front = 0; m_valid = 0; m_swap = 0;
        m_rd = 0; m_wr = 0; m_acc = 0; m_occ = 0;
        rd_q.delete();
        wr_q.delete();
    endtask

    // Monitor: every strobe must match the next expected transaction of its kind.
    logic [23:0] mon_ra;
    wr_t         mon_w;
    always @(negedge iCLK) begin
        if (iRST_n === 1'b1) begin
            check("rd_wr_exclusive", 64'(oMEM_RD && oMEM_WR), 64'd0);
            if (oMEM_RD) begin
                if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
                else begin
                    mon_ra = rd_q.pop_front();
                    check("rd_addr", 64'(oMEM_ADDR), 64'(mon_ra));
                end
            end else if (oMEM_WR) begin
                if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
                else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", 64'(oMEM_ADDR), 64'(mon_w.a));
                    check("wr_data", 64'(oMEM_WDATA), 64'(mon_w.d));
                end
            end else begin
                check("idle_bus", {8'd0, oMEM_ADDR, oMEM_WDATA}, 64'd0);
            end
        end
    end

    // One clock of stimulus; exp_addr >= 0 adds a hand-computed address check.
    task automatic tick(input logic rd, input logic vld, input logic nf,
                        input logic [31:0] d, input int exp_addr);
        bit exp_ready, drain, acc, old_fill;
        int old_wr;
        iRD_REQ   = rd;
        iWR_VALID = vld;
        iNewFrame = nf;
        iWR_DATA  = d;
        exp_ready = m_fill && (m_occ < 4) && (m_acc < FW);
        drain     = (m_occ > 0) && !rd;
        acc       = vld && exp_ready;
        if (rd)  rd_q.push_back(bb(m_front) + 24'(m_rd));
        if (acc) wr_q.push_back({bb(!m_front) + 24'(m_acc), d});
        @(negedge iCLK);
        check("wr_ready", 64'(oWR_READY), 64'(exp_ready));
        check("mem_wr", 64'(oMEM_WR), 64'(drain));
        if (exp_addr >= 0) check("hand_addr", 64'(oMEM_ADDR), 64'(exp_addr));
        old_fill = m_fill;
        old_wr   = m_wr;
        m_occ = m_occ + int'(acc) - int'(drain);
        m_wr  = m_wr + int'(drain);
        m_acc = m_acc + int'(acc);
        if (nf) m_rd = 0;
        else if (rd) m_rd = (m_rd == FW - 1) ? 0 : m_rd + 1;
        m_swap = 0;
        if (!old_fill && nf) begin
            m_front = !m_front; m_wr = 0; m_acc = 0;
            m_valid = 1; m_swap = 1; m_fill = 1;
        end else if (old_fill && old_wr == FW) begin
            m_fill = 0;
        end
        @(posedge iCLK);
        #1;
        check("frame_swap", 64'(oFrameSwap), 64'(m_swap));
        check("buf_valid", 64'(oBufValid), 64'(m_valid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST_n = 1'b0; iNewFrame = 0; iRD_REQ = 0; iWR_VALID = 0; iWR_DATA = '0;
        model_reset();
        #2;
        check("rst_mem_rd", 64'(oMEM_RD), 64'd0);
        check("rst_mem_wr", 64'(oMEM_WR), 64'd0);
        check("rst_addr", 64'(oMEM_ADDR), 64'd0);
        check("rst_wdata", 64'(oMEM_WDATA), 64'd0);
        check("rst_swap", 64'(oFrameSwap), 64'd0);
        check("rst_bufvalid", 64'(oBufValid), 64'd0);
        check("rst_ready", 64'(oWR_READY), 64'd1);
        #11 iRST_n = 1'b1;
        @(posedge iCLK); #1;

        // Partial fill held in the FIFO by reads, then async reset with no clock.
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 32'hC0 + 32'(i), i);
        iRD_REQ = 0; iWR_VALID = 0; iRST_n = 0;
        #1;
        check("arst_ready", 64'(oWR_READY), 64'd1);
        check("arst_mem_wr", 64'(oMEM_WR), 64'd0);
        check("arst_rd_cnt", 64'(dut.rd_cnt_q), 64'd0);
        check("arst_acc_cnt", 64'(dut.acc_cnt_q), 64'd0);
        model_reset();
        @(negedge iCLK); #2 iRST_n = 1;
        @(posedge iCLK); #1;

        // Full frame into back buffer (base 16).
        for (int i = 0; i < FW; i++) tick(0, 1, 0, 32'hA0 + 32'(i), (i == 1) ? 16 : -1);
        tick(0, 0, 0, 0, 31);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, -1);
        check("s2_state_ready", 64'(dut.state_q), 64'(S_READY));
        check("s2_ready_low", 64'(oWR_READY), 64'd0);

        // Swap, then reads from the new front at 16.
        tick(0, 0, 1, 0, -1);
        check("s4_front", 64'(dut.front_q), 64'd1);
        tick(0, 0, 0, 0, -1);
        tick(1, 0, 0, 0, 16);
        tick(1, 0, 0, 0, 17);
        tick(1, 0, 0, 0, 18);

        // Reads block writes; FIFO fills, then drains back to back at base 0.
        for (int i = 0; i < 6; i++) tick(1, 1, 0, 32'hB0 + 32'(i), 19 + i);
        check("s3_full_ready", 64'(oWR_READY), 64'd0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, i);
        tick(0, 0, 0, 0, -1);

        // New frame while filling: no swap, read counter restarts, wraps after 16.
        tick(1, 0, 1, 0, 25);
        for (int i = 0; i < 17; i++) tick(1, 0, 0, 0, (i == 0 || i == 16) ? 16 : -1);
        for (int i = 0; i < 12; i++) tick(0, 1, 0, 32'hD0 + 32'(i), -1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, -1);
        check("s5_state_ready", 64'(dut.state_q), 64'(S_READY));

        // New frame coincident with a read in S_READY: old front this cycle, new front next.
        tick(1, 0, 1, 0, 17);
        tick(1, 0, 0, 0, 0);

        // Random read bursts against writes.
        for (int i = 0; i < 80; i++)
            tick(logic'($urandom_range(0, 99) < 40), logic'($urandom_range(0, 1)), 0, $urandom, -1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, -1);
        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
